// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spi_bus_arbiter
// Purpose : Round-robin sharing of one byte-level SPI engine between two
//           requesters, each with its own active-low chip select. Defining
//           SPI_ARB_TIMEOUT_EN adds a forced release after TIMEOUT idle XFER
//           cycles.
// Rev     : 1.0  initial release
// ============================================================================
module spi_bus_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [1:0] tx_valid,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] tx_ready,
  output logic [7:0] rx_data,
  output logic [1:0] rx_valid,
  output logic       eng_start,
  output logic [7:0] eng_tx,
  input  logic       eng_done,
  input  logic [7:0] eng_rx,
  output logic [1:0] ssn
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic [1:0] timeout
`endif
);

  if (CS_SETUP < 1 || CS_SETUP > 255) begin : g_bad_cs_setup
    $error("spi_bus_arbiter: CS_SETUP must be 1..255");
  end
  if (CS_HOLD < 1 || CS_HOLD > 255) begin : g_bad_cs_hold
    $error("spi_bus_arbiter: CS_HOLD must be 1..255");
  end
  if (GAP < 1 || GAP > 255) begin : g_bad_gap
    $error("spi_bus_arbiter: GAP must be 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("spi_bus_arbiter: TIMEOUT must be 1..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

  state_t     r_state, w_state_nxt;
  logic       r_sel, w_sel_nxt;
  logic       r_last, w_last_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [1:0] w_gnt_nxt, w_ssn_nxt;
  logic [1:0] w_sel_oh, w_eligible;
  logic       w_pick, w_accept, w_expire;
  logic [7:0] w_tx_byte;

  assign w_sel_oh  = r_sel ? 2'b10 : 2'b01;
  assign w_tx_byte = r_sel ? tx_data1 : tx_data0;
  assign w_accept  = (r_state == S_XFER) && tx_valid[r_sel];
  assign tx_ready  = (r_state == S_XFER) ? w_sel_oh : 2'b00;
  // On a tie the requester that did not win last time gets the bus.
  assign w_pick    = (w_eligible == 2'b11) ? ~r_last : w_eligible[1];

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [1:0]  r_locked;
  logic        w_idle;

  assign w_idle   = (r_state == S_XFER) && !tx_valid[r_sel] && req[r_sel];
  assign w_expire = w_idle && (r_idle_cnt == TIMEOUT_LAST);
  // A force-released requester stays ineligible until it drops req once.
  assign w_eligible = req & ~r_locked;

  always_comb begin
    w_idle_cnt_nxt = 16'd0;
    if (w_idle && !w_expire) begin
      w_idle_cnt_nxt = r_idle_cnt + 16'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_idle_cnt <= 16'd0;
      r_locked   <= 2'b00;
      timeout    <= 2'b00;
    end else begin
      r_idle_cnt <= w_idle_cnt_nxt;
      r_locked   <= (r_locked & req) | (w_expire ? w_sel_oh : 2'b00);
      timeout    <= w_expire ? w_sel_oh : 2'b00;
    end
  end
`else
  assign w_expire   = 1'b0;
  assign w_eligible = req;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = gnt;
    w_ssn_nxt   = ssn;
    case (r_state)
      S_IDLE: begin
        if (|w_eligible) begin
          w_sel_nxt   = w_pick;
          w_last_nxt  = w_pick;
          w_gnt_nxt   = w_pick ? 2'b10 : 2'b01;
          w_ssn_nxt   = w_pick ? 2'b01 : 2'b10;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_XFER;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_XFER: begin
        // A pending byte beats a simultaneous req drop.
        if (tx_valid[r_sel]) begin
          w_state_nxt = S_WAIT;
        end else if (!req[r_sel] || w_expire) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_HOLD;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          w_state_nxt = S_XFER;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt   = 8'd0;
          w_gnt_nxt   = 2'b00;
          w_ssn_nxt   = 2'b11;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_cnt_nxt   = 8'd0;
        w_gnt_nxt   = 2'b00;
        w_ssn_nxt   = 2'b11;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt       <= 2'b00;
      ssn       <= 2'b11;
      eng_start <= 1'b0;
      eng_tx    <= 8'd0;
      rx_data   <= 8'd0;
      rx_valid  <= 2'b00;
    end else begin
      gnt       <= w_gnt_nxt;
      ssn       <= w_ssn_nxt;
      eng_start <= w_accept;
      if (w_accept) begin
        eng_tx <= w_tx_byte;
      end
      rx_valid <= 2'b00;
      if ((r_state == S_WAIT) && eng_done) begin
        rx_data  <= eng_rx;
        rx_valid <= w_sel_oh;
      end
    end
  end

`ifndef SYNTHESIS
  a_single_cs: assert property (@(posedge HCLK) disable iff (!HRESETn) ssn != 2'b00);
  a_start_in_wait: assert property (@(posedge HCLK) disable iff (!HRESETn)
                                    eng_start |-> (r_state == S_WAIT));
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_bus_arbiter
// Purpose : Directed self-checking bench for spi_bus_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spi_bus_arbiter;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int GAP      = 4;
  localparam int TIMEOUT  = 16;

  logic       HCLK     = 1'b0;
  logic       HRESETn  = 1'b0;
  logic [1:0] req      = 2'b00;
  logic [1:0] tx_valid = 2'b00;
  logic [7:0] tx_data0 = 8'h00;
  logic [7:0] tx_data1 = 8'h00;
  logic       eng_done = 1'b0;
  logic [7:0] eng_rx   = 8'h00;
  logic [1:0] gnt, tx_ready, rx_valid, ssn;
  logic [7:0] rx_data, eng_tx;
  logic       eng_start;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [1:0] timeout;
`endif

  int   checks    = 0;
  int   failures  = 0;
  logic mon_en    = 1'b0;
  int   viol      = 0;
  int   start_cnt = 0;

  spi_bus_arbiter #(
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .req      (req),
    .gnt      (gnt),
    .tx_valid (tx_valid),
    .tx_data0 (tx_data0),
    .tx_data1 (tx_data1),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .eng_start(eng_start),
    .eng_tx   (eng_tx),
    .eng_done (eng_done),
    .eng_rx   (eng_rx),
    .ssn      (ssn)
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  always #5 HCLK = ~HCLK;

  // Requester 1 must never see the bus while requester 0 owns it.
  always @(negedge HCLK) begin
    if (eng_start) start_cnt <= start_cnt + 1;
    if (mon_en && (tx_ready[1] || !ssn[1] || rx_valid[1] || (eng_start && eng_tx == 8'h55)))
      viol <= viol + 1;
  end

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic apply_reset();
    HRESETn = 1'b0; req = 2'b00; tx_valid = 2'b00; tx_data0 = 8'h00; tx_data1 = 8'h00;
    eng_done = 1'b0; eng_rx = 8'h00;
    tick(); tick();
    HRESETn = 1'b1;
    tick();
  endtask

  // One byte for requester r; engine answers e one cycle after eng_start.
  task automatic do_byte(input int r, input logic [7:0] b, input logic [7:0] e);
    logic [1:0] oh;
    oh = (r == 1) ? 2'b10 : 2'b01;
    checks++;
    if (tx_ready !== oh) begin failures++; $display("FAIL byte_ready got=%b exp=%b", tx_ready, oh); end
    tx_valid[r] = 1'b1;
    if (r == 1) tx_data1 = b; else tx_data0 = b;
    tick();
    tx_valid[r] = 1'b0;
    checks++;
    if (eng_start !== 1'b1 || eng_tx !== b) begin
      failures++; $display("FAIL byte_start got start=%b tx=%h exp start=1 tx=%h", eng_start, eng_tx, b);
    end
    checks++;
    if (tx_ready !== 2'b00) begin failures++; $display("FAIL byte_wait_ready got=%b exp=00", tx_ready); end
    tick();
    checks++;
    if (eng_start !== 1'b0) begin failures++; $display("FAIL byte_start_pulse got=%b exp=0", eng_start); end
    eng_done = 1'b1; eng_rx = e;
    tick();
    eng_done = 1'b0; eng_rx = 8'h00;
    checks++;
    if (rx_valid !== oh || rx_data !== e) begin
      failures++; $display("FAIL byte_rx got valid=%b data=%h exp valid=%b data=%h", rx_valid, rx_data, oh, e);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    tick(); tick();
    checks++; if (gnt !== 2'b00)       begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (ssn !== 2'b11)       begin failures++; $display("FAIL reset_ssn got=%b exp=11", ssn); end
    checks++; if (tx_ready !== 2'b00)  begin failures++; $display("FAIL reset_tx_ready got=%b exp=00", tx_ready); end
    checks++; if (rx_valid !== 2'b00)  begin failures++; $display("FAIL reset_rx_valid got=%b exp=00", rx_valid); end
    checks++; if (eng_start !== 1'b0)  begin failures++; $display("FAIL reset_eng_start got=%b exp=0", eng_start); end
    checks++; if (eng_tx !== 8'h00)    begin failures++; $display("FAIL reset_eng_tx got=%h exp=00", eng_tx); end
    checks++; if (rx_data !== 8'h00)   begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    req = 2'b01;
    tick();
    checks++;
    if (ssn !== 2'b10 || gnt !== 2'b01 || tx_ready !== 2'b00) begin
      failures++; $display("FAIL single_setup1 got ssn=%b gnt=%b rdy=%b exp 10 01 00", ssn, gnt, tx_ready);
    end
    tick();
    checks++;
    if (ssn !== 2'b10 || tx_ready !== 2'b00) begin
      failures++; $display("FAIL single_setup2 got ssn=%b rdy=%b exp 10 00", ssn, tx_ready);
    end
    tick();
    do_byte(0, 8'h03, 8'hA5);
    do_byte(0, 8'h00, 8'hA5);
    do_byte(0, 8'h10, 8'hA5);
    req = 2'b00;
    tick();
    checks++;
    if (ssn !== 2'b10 || gnt !== 2'b01 || rx_valid !== 2'b00) begin
      failures++; $display("FAIL single_hold1 got ssn=%b gnt=%b rxv=%b exp 10 01 00", ssn, gnt, rx_valid);
    end
    tick();
    checks++;
    if (ssn !== 2'b10) begin failures++; $display("FAIL single_hold2 got ssn=%b exp=10", ssn); end
    tick();
    checks++;
    if (ssn !== 2'b11 || gnt !== 2'b00) begin
      failures++; $display("FAIL single_release got ssn=%b gnt=%b exp 11 00", ssn, gnt);
    end
  endtask

  task automatic test_blocking();
    apply_reset();
    req = 2'b01;
    tick();
    req = 2'b11; tx_valid = 2'b10; tx_data1 = 8'h55;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx_ready == 2'b01) break;
      tick();
    end
    do_byte(0, 8'h3C, 8'h77);
    req = 2'b00; tx_valid = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (ssn == 2'b11) break;
      tick();
    end
    mon_en = 1'b0;
    tick();
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL block_req1 got violations=%0d exp=0", viol); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b01 || ssn !== 2'b10) begin
      failures++; $display("FAIL rr_first got gnt=%b ssn=%b exp 01 10", gnt, ssn);
    end
    tick(); tick();
    req = 2'b10;
    tick(); tick();
    checks++;
    if (gnt !== 2'b01 || ssn !== 2'b10) begin
      failures++; $display("FAIL rr_hold got gnt=%b ssn=%b exp 01 10", gnt, ssn);
    end
    tick();
    checks++;
    if (gnt !== 2'b00 || ssn !== 2'b11) begin
      failures++; $display("FAIL rr_release got gnt=%b ssn=%b exp 00 11", gnt, ssn);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (gnt !== 2'b00 || ssn !== 2'b11) begin
      failures++; $display("FAIL rr_gap got gnt=%b ssn=%b exp 00 11", gnt, ssn);
    end
    tick();
    checks++;
    if (gnt !== 2'b10 || ssn !== 2'b01) begin
      failures++; $display("FAIL rr_second got gnt=%b ssn=%b exp 10 01", gnt, ssn);
    end
    tick(); tick();
    req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      if (ssn == 2'b11) break;
      tick();
    end
    req = 2'b11;
    for (int i = 0; i < 20; i++) begin
      if (gnt != 2'b00) break;
      tick();
    end
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL rr_tie_to0 got gnt=%b exp=01", gnt); end
    for (int i = 0; i < 20; i++) begin
      if (tx_ready == 2'b01) break;
      tick();
    end
    req = 2'b10;
    for (int i = 0; i < 20; i++) begin
      if (ssn == 2'b11) break;
      tick();
    end
    req = 2'b11;
    for (int i = 0; i < 20; i++) begin
      if (gnt != 2'b00) break;
      tick();
    end
    checks++;
    if (gnt !== 2'b10) begin failures++; $display("FAIL rr_tie_to1 got gnt=%b exp=10", gnt); end
    req = 2'b00;
  endtask

  task automatic test_drop_wait();
    int starts_before;
    apply_reset();
    req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      if (tx_ready == 2'b01) break;
      tick();
    end
    starts_before = start_cnt;
    tx_valid[0] = 1'b1; tx_data0 = 8'h5A;
    tick();
    tx_valid[0] = 1'b0;
    tick();
    req = 2'b00;
    tick();
    eng_done = 1'b1; eng_rx = 8'h3E;
    tick();
    eng_done = 1'b0; eng_rx = 8'h00;
    checks++;
    if (rx_valid !== 2'b01 || rx_data !== 8'h3E) begin
      failures++; $display("FAIL drop_rx got valid=%b data=%h exp 01 3e", rx_valid, rx_data);
    end
    tick();
    checks++;
    if (tx_ready !== 2'b00 || gnt !== 2'b01 || ssn !== 2'b10) begin
      failures++; $display("FAIL drop_hold got rdy=%b gnt=%b ssn=%b exp 00 01 10", tx_ready, gnt, ssn);
    end
    tick(); tick();
    checks++;
    if (ssn !== 2'b11) begin failures++; $display("FAIL drop_release got ssn=%b exp=11", ssn); end
    tick(); tick();
    checks++;
    if (start_cnt - starts_before !== 1) begin
      failures++; $display("FAIL drop_starts got=%0d exp=1", start_cnt - starts_before);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      if (tx_ready == 2'b01) break;
      tick();
    end
    tx_valid[0] = 1'b1; tx_data0 = 8'hC3;
    tick();
    tx_valid[0] = 1'b0;
    checks++;
    if (eng_start !== 1'b1 || ssn !== 2'b10) begin
      failures++; $display("FAIL arst_pre got start=%b ssn=%b exp 1 10", eng_start, ssn);
    end
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if (ssn !== 2'b11 || gnt !== 2'b00 || eng_start !== 1'b0) begin
      failures++; $display("FAIL arst_now got ssn=%b gnt=%b start=%b exp 11 00 0", ssn, gnt, eng_start);
    end
    checks++;
    if (eng_tx !== 8'h00 || tx_ready !== 2'b00) begin
      failures++; $display("FAIL arst_data got eng_tx=%h rdy=%b exp 00 00", eng_tx, tx_ready);
    end
    tick();
    HRESETn = 1'b1; req = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL arst_tie got gnt=%b exp=01", gnt); end
    req = 2'b00;
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int busy;
    apply_reset();
    req = 2'b01;
    tick();
    for (int i = 1; i <= 17; i++) tick();
    checks++;
    if (timeout !== 2'b00 || tx_ready !== 2'b01) begin
      failures++; $display("FAIL to_before got to=%b rdy=%b exp 00 01", timeout, tx_ready);
    end
    tick();
    checks++;
    if (timeout !== 2'b01 || ssn !== 2'b10 || tx_ready !== 2'b00) begin
      failures++; $display("FAIL to_fire got to=%b ssn=%b rdy=%b exp 01 10 00", timeout, ssn, tx_ready);
    end
    tick();
    checks++;
    if (timeout !== 2'b00) begin failures++; $display("FAIL to_pulse got=%b exp=00", timeout); end
    tick();
    checks++;
    if (ssn !== 2'b11) begin failures++; $display("FAIL to_release got ssn=%b exp=11", ssn); end
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt != 2'b00) busy++;
    end
    checks++;
    if (busy !== 0) begin failures++; $display("FAIL to_lockout got grant_cycles=%0d exp=0", busy); end
    req = 2'b00;
    tick();
    req = 2'b01;
    for (int i = 0; i < 10; i++) begin
      if (gnt != 2'b00) break;
      tick();
    end
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL to_regrant got gnt=%b exp=01", gnt); end
    req = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_blocking();
    test_round_robin();
    test_drop_wait();
    test_async_reset();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
